fp_div: RTL and testbench

- Sequential IEEE-754 single-precision (binary32) divider: result = a / b.
- Iterative restoring mantissa division, round-to-nearest-even, exception coding for special operands.
- Sits as a multi-cycle functional unit beside the FP datapath; the host pulses start and waits for done.

---
 rtl/fp_pkg.sv | 45 ++++
 rtl/fp_div_mant_iter.sv | 42 ++++
 rtl/fp_div.sv | 190 +++++++++++++++++++
 tb/tb_fp_div.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared binary32 constants, exception coding, FSM states and operand classification
// for the floating-point divider.
package fp_pkg;
   localparam int EXP_W  = 8;
   localparam int MAN_W  = 23;
   localparam int BIAS   = 127;
   localparam int ITER_N = 27;
   localparam logic [31:0] QNAN = 32'h7FC00000;

   typedef enum logic [1:0] {
      EXC_NONE    = 2'b00,
      EXC_DIV0    = 2'b01,
      EXC_INVALID = 2'b10,
      EXC_RANGE   = 2'b11
   } exc_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_UNPACK,
      ST_ITER,
      ST_ROUND
   } state_t;

   typedef struct packed {
      logic is_zero;
      logic is_inf;
      logic is_nan;
      logic is_denorm;
   } fp_class_t;

   function automatic fp_class_t fp_classify(input logic [31:0] x);
      fp_class_t c;
      logic exp_zero;
      logic exp_ones;
      logic frac_zero;
      exp_zero    = (x[EXP_W+MAN_W-1:MAN_W] == '0);
      exp_ones    = (x[EXP_W+MAN_W-1:MAN_W] == '1);
      frac_zero   = (x[MAN_W-1:0] == '0);
      c.is_zero   = exp_zero & frac_zero;
      c.is_denorm = exp_zero & ~frac_zero;
      c.is_inf    = exp_ones & frac_zero;
      c.is_nan    = exp_ones & ~frac_zero;
      return c;
   endfunction
endpackage

// File: rtl/fp_div_mant_iter.sv
// Restoring mantissa divider: one quotient bit per enabled step, MSB first,
// remainder doubled after each compare/subtract.
module fp_div_mant_iter
   import fp_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
   input  logic [MAN_W:0]   ma,
   input  logic [MAN_W:0]   mb,
   output logic [MAN_W+3:0] q,
   output logic [MAN_W+1:0] rem
);
   logic [MAN_W:0]   mb_reg;
   logic [MAN_W+3:0] q_reg;
   logic [MAN_W+1:0] rem_reg;
   logic [MAN_W+1:0] rem_sel;
   logic             ge;

   // rem stays below 2*mb, so the doubled remainder always fits in MAN_W+2 bits
   assign ge      = (rem_reg >= {1'b0, mb_reg});
   assign rem_sel = ge ? (rem_reg - {1'b0, mb_reg}) : rem_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mb_reg  <= '0;
         q_reg   <= '0;
         rem_reg <= '0;
      end else if (load) begin
         mb_reg  <= mb;
         q_reg   <= '0;
         rem_reg <= {1'b0, ma};
      end else if (step) begin
         q_reg   <= {q_reg[MAN_W+2:0], ge};
         rem_reg <= rem_sel << 1;
      end
   end

   assign q   = q_reg;
   assign rem = rem_reg;
endmodule

// File: rtl/fp_div.sv
// Sequential binary32 divider: UNPACK, 27 restoring iterations, round-to-nearest-even,
// with special operands resolved during UNPACK and emitted at the same fixed latency.
module fp_div
   import fp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result,
   output logic        done,
   output logic [1:0]  exception
);
   localparam logic signed [EXP_W+1:0] BIAS_S = 10'(BIAS);

   state_t state_reg, state_next;

   logic [31:0]              a_reg, b_reg;
   logic [4:0]               cnt_reg;
   logic                     sign_reg;
   logic signed [EXP_W+1:0]  exp_reg;
   logic                     special_reg;
   logic [31:0]              spec_res_reg;
   exc_t                     spec_exc_reg;
   logic [31:0]              result_reg;
   exc_t                     exc_reg;
   logic                     done_reg;

   logic                     load, step;
   logic [MAN_W+3:0]         q_w;
   logic [MAN_W+1:0]         rem_w;

   fp_class_t                ca, cb;
   logic                     za, zb;
   logic                     sign_unp;
   logic signed [EXP_W+1:0]  exp_unp;
   logic                     sp_hit;
   logic [31:0]              sp_res;
   exc_t                     sp_exc;

   logic                     msb, guard, sticky, round_up, carry;
   logic [MAN_W:0]           sig;
   logic [MAN_W+1:0]         sum;
   logic signed [EXP_W+1:0]  exp_adj, exp_fin;
   logic [31:0]              rnd_res;
   exc_t                     rnd_exc;

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      load       = 1'b0;
      step       = 1'b0;
      if (start) begin
         state_next = ST_UNPACK;
      end else begin
         unique case (state_reg)
            ST_IDLE:   state_next = ST_IDLE;
            ST_UNPACK: begin
               load       = 1'b1;
               state_next = ST_ITER;
            end
            ST_ITER: begin
               step = 1'b1;
               if (cnt_reg == 5'(ITER_N - 1)) state_next = ST_ROUND;
            end
            ST_ROUND:  state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
         endcase
      end
   end

   // ---------------- unpack and special-operand decode ----------------
   assign ca       = fp_classify(a_reg);
   assign cb       = fp_classify(b_reg);
   assign za       = ca.is_zero | ca.is_denorm;
   assign zb       = cb.is_zero | cb.is_denorm;
   assign sign_unp = a_reg[31] ^ b_reg[31];
   assign exp_unp  = $signed({2'b00, a_reg[30:23]}) - $signed({2'b00, b_reg[30:23]}) + BIAS_S;

   always_comb begin
      sp_hit = 1'b1;
      sp_res = QNAN;
      sp_exc = EXC_INVALID;
      if (ca.is_nan | cb.is_nan | (za & zb) | (ca.is_inf & cb.is_inf)) begin
         sp_res = QNAN;
         sp_exc = EXC_INVALID;
      end else if (zb) begin
         sp_res = {sign_unp, 8'hFF, 23'd0};
         sp_exc = EXC_DIV0;
      end else if (ca.is_inf) begin
         sp_res = {sign_unp, 8'hFF, 23'd0};
         sp_exc = EXC_NONE;
      end else if (cb.is_inf | za) begin
         sp_res = {sign_unp, 31'd0};
         sp_exc = EXC_NONE;
      end else begin
         sp_hit = 1'b0;
         sp_res = '0;
         sp_exc = EXC_NONE;
      end
   end

   fp_div_mant_iter u_iter (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .step  (step),
      .ma    ({1'b1, a_reg[MAN_W-1:0]}),
      .mb    ({1'b1, b_reg[MAN_W-1:0]}),
      .q     (q_w),
      .rem   (rem_w)
   );

   // ---------------- normalise and round ----------------
   always_comb begin
      msb      = q_w[MAN_W+3];
      sig      = q_w[MAN_W+3:3];
      guard    = q_w[2];
      sticky   = (|q_w[1:0]) | (|rem_w);
      exp_adj  = exp_reg;
      if (!msb) begin
         sig     = q_w[MAN_W+2:2];
         guard   = q_w[1];
         sticky  = q_w[0] | (|rem_w);
         exp_adj = exp_reg - 10'sd1;
      end
      round_up = guard & (sticky | sig[0]);
      sum      = {1'b0, sig} + {{(MAN_W+1){1'b0}}, round_up};
      carry    = sum[MAN_W+1];
      exp_fin  = exp_adj + $signed({9'd0, carry});
      rnd_res  = {sign_reg, exp_fin[7:0], carry ? sum[MAN_W:1] : sum[MAN_W-1:0]};
      rnd_exc  = EXC_NONE;
      if (exp_fin >= 10'sd255) begin
         rnd_res = {sign_reg, 8'hFF, 23'd0};
         rnd_exc = EXC_RANGE;
      end else if (exp_fin <= 10'sd0) begin
         rnd_res = {sign_reg, 31'd0};
         rnd_exc = EXC_RANGE;
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg        <= '0;
         b_reg        <= '0;
         cnt_reg      <= '0;
         sign_reg     <= 1'b0;
         exp_reg      <= '0;
         special_reg  <= 1'b0;
         spec_res_reg <= '0;
         spec_exc_reg <= EXC_NONE;
         result_reg   <= '0;
         exc_reg      <= EXC_NONE;
         done_reg     <= 1'b0;
      end else if (start) begin
         a_reg    <= a;
         b_reg    <= b;
         done_reg <= 1'b0;
      end else begin
         unique case (state_reg)
            ST_UNPACK: begin
               sign_reg     <= sign_unp;
               exp_reg      <= exp_unp;
               special_reg  <= sp_hit;
               spec_res_reg <= sp_res;
               spec_exc_reg <= sp_exc;
               cnt_reg      <= '0;
            end
            ST_ITER:  cnt_reg <= cnt_reg + 5'd1;
            ST_ROUND: begin
               result_reg <= special_reg ? spec_res_reg : rnd_res;
               exc_reg    <= special_reg ? spec_exc_reg : rnd_exc;
               done_reg   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign result    = result_reg;
   assign done      = done_reg;
   assign exception = exc_reg;
endmodule

// File: tb/tb_fp_div.sv
// Scoreboard bench for fp_div: expected quotients come from a double-precision
// reference rounded to binary32, or from fixed values for special operands.
module tb_fp_div;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [31:0] result;
   logic        done;
   logic [1:0]  exception;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [1:0]  exc;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] last_res = '0;

   always #5 clk = ~clk;

   fp_div dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .a         (a),
      .b         (b),
      .result    (result),
      .done      (done),
      .exception (exception)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic real f2r(input logic [31:0] x);
      logic [63:0] d;
      if (x[30:23] == 8'd0) return 0.0;
      d = {x[31], 11'({3'b000, x[30:23]} + 11'd896), x[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   // Independent reference: double division then RNE to 24 bits, no subnormal outputs.
   function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] r, output logic [1:0] e);
      logic        zx, zy, ix, iy, nx, ny, s, g, st, rnd;
      logic [63:0] d;
      logic [52:0] m;
      logic [24:0] sum;
      logic [23:0] sig;
      int          fe;
      real         qv;
      zx = (x[30:23] == 8'd0);
      zy = (y[30:23] == 8'd0);
      ix = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
      iy = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
      nx = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
      ny = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
      s  = x[31] ^ y[31];
      if (nx || ny || (zx && zy) || (ix && iy)) begin
         r = 32'h7FC00000; e = 2'b10;
      end else if (zy) begin
         r = {s, 8'hFF, 23'd0}; e = 2'b01;
      end else if (ix) begin
         r = {s, 8'hFF, 23'd0}; e = 2'b00;
      end else if (iy || zx) begin
         r = {s, 31'd0}; e = 2'b00;
      end else begin
         qv  = f2r(x) / f2r(y);
         d   = $realtobits(qv);
         fe  = int'(d[62:52]) - 896;
         m   = {1'b1, d[51:0]};
         sig = m[52:29];
         g   = m[28];
         st  = |m[27:0];
         rnd = g & (st | sig[0]);
         sum = {1'b0, sig} + {24'd0, rnd};
         if (sum[24]) begin
            sig = sum[24:1];
            fe  = fe + 1;
         end else begin
            sig = sum[23:0];
         end
         if (fe >= 255) begin
            r = {s, 8'hFF, 23'd0}; e = 2'b11;
         end else if (fe <= 0) begin
            r = {s, 31'd0}; e = 2'b11;
         end else begin
            r = {s, 8'(fe), sig[22:0]}; e = 2'b00;
         end
      end
   endfunction

   task automatic push_model(input logic [31:0] av, input logic [31:0] bv);
      exp_t t;
      t.a = av;
      t.b = bv;
      model(av, bv, t.res, t.exc);
      sb.push_back(t);
   endtask

   task automatic push_const(input logic [31:0] av, input logic [31:0] bv,
                             input logic [31:0] rv, input logic [1:0] ev);
      exp_t t;
      t.a = av; t.b = bv; t.res = rv; t.exc = ev;
      sb.push_back(t);
   endtask

   task automatic drive_start(input logic [31:0] av, input logic [31:0] bv);
      @(negedge clk);
      a     = av;
      b     = bv;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL done_clear: done=%b after start edge, required 0", done);
      end
   endtask

   task automatic wait_done(output int cyc);
      cyc = 1;
      @(posedge clk);
      #1;
      while (!done && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic check_result(input int cyc);
      exp_t t;
      n_checks++;
      if (cyc != 29) begin
         n_fail++;
         $display("FAIL latency: done after %0d edges, required 29", cyc);
      end
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard: result %h with no expected entry", result);
         return;
      end
      t = sb.pop_front();
      n_checks++;
      if (result !== t.res) begin
         n_fail++;
         $display("FAIL result a=%h b=%h: got %h, required %h", t.a, t.b, result, t.res);
      end
      n_checks++;
      if (exception !== t.exc) begin
         n_fail++;
         $display("FAIL exception a=%h b=%h: got %b, required %b", t.a, t.b, exception, t.exc);
      end
      last_res = result;
      $display("txn a=%h b=%h result=%h exc=%b latency=%0d", t.a, t.b, result, exception, cyc);
   endtask

   task automatic run_op(input logic [31:0] av, input logic [31:0] bv);
      int cyc;
      drive_start(av, bv);
      wait_done(cyc);
      check_result(cyc);
   endtask

   task automatic check_ulp(input string name, input logic [31:0] ref_v);
      int diff;
      diff = int'(last_res) - int'(ref_v);
      if (diff < 0) diff = -diff;
      n_checks++;
      if (diff > 1) begin
         n_fail++;
         $display("FAIL %s: got %h, required within 1 ulp of %h", name, last_res, ref_v);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_checks++;
      if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h, required 0", result); end
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, required 0", done); end
      n_checks++;
      if (exception !== 2'b00) begin n_fail++; $display("FAIL reset_exc: got %b, required 00", exception); end
      rst_n = 1'b1;
   endtask

   task automatic test_normal();
      push_model(32'h3F28F5C3, 32'h3F028F5C); run_op(32'h3F28F5C3, 32'h3F028F5C);
      push_model(32'h40866666, 32'h404CCCCD); run_op(32'h40866666, 32'h404CCCCD);
      check_ulp("ulp_4.2/3.2", 32'h3FA80000);
      push_model(32'h4034B4B5, 32'h3F70F0F1); run_op(32'h4034B4B5, 32'h3F70F0F1);
      check_ulp("ulp_3.0", 32'h40400000);
      push_const(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 2'b00); run_op(32'h3F800000, 32'h40400000);
   endtask

   task automatic test_sign();
      push_const(32'hC0CCCCCD, 32'hBF000000, 32'h414CCCCD, 2'b00); run_op(32'hC0CCCCCD, 32'hBF000000);
      push_const(32'h40CCCCCD, 32'hBF000000, 32'hC14CCCCD, 2'b00); run_op(32'h40CCCCCD, 32'hBF000000);
   endtask

   task automatic test_specials();
      logic [31:0] tab [11][4];
      tab = '{
         '{32'h3F800000, 32'h00000000, 32'h7F800000, 32'd1},
         '{32'h00000000, 32'h00000000, 32'h7FC00000, 32'd2},
         '{32'h7F000000, 32'h00800000, 32'h7F800000, 32'd3},
         '{32'h00800000, 32'h7F000000, 32'h00000000, 32'd3},
         '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 32'd2},
         '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'd2},
         '{32'hFF800000, 32'h40000000, 32'hFF800000, 32'd0},
         '{32'h40000000, 32'hFF800000, 32'h80000000, 32'd0},
         '{32'h80000000, 32'h40400000, 32'h80000000, 32'd0},
         '{32'h00000001, 32'h40000000, 32'h00000000, 32'd0},
         '{32'hC0000000, 32'h00000005, 32'hFF800000, 32'd1}
      };
      for (int i = 0; i < 11; i++) begin
         push_const(tab[i][0], tab[i][1], tab[i][2], tab[i][3][1:0]);
         run_op(tab[i][0], tab[i][1]);
      end
   endtask

   task automatic test_random();
      logic [31:0] av, bv;
      for (int i = 0; i < 16; i++) begin
         av = {1'($urandom), 8'($urandom_range(154, 100)), 23'($urandom)};
         bv = {1'($urandom), 8'($urandom_range(154, 100)), 23'($urandom)};
         push_model(av, bv);
         run_op(av, bv);
      end
   endtask

   task automatic test_done_hold();
      logic [31:0] held;
      push_model(32'h41200000, 32'h40E00000); run_op(32'h41200000, 32'h40E00000);
      held = last_res;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (done !== 1'b1 || result !== held) begin
            n_fail++;
            $display("FAIL done_hold: done=%b result=%h, required 1 and %h", done, result, held);
         end
      end
   endtask

   task automatic test_back_to_back();
      push_model(32'h3FC00000, 32'h3F400000); run_op(32'h3FC00000, 32'h3F400000);
      push_model(32'hC2F6E979, 32'h3E4CCCCD); run_op(32'hC2F6E979, 32'h3E4CCCCD);
      push_model(32'h4B000001, 32'h3F7FFFFF); run_op(32'h4B000001, 32'h3F7FFFFF);
   endtask

   task automatic test_restart();
      int cyc;
      drive_start(32'h40490FDB, 32'h402DF854);
      repeat (10) @(posedge clk);
      push_model(32'h42C80000, 32'h41100000);
      drive_start(32'h42C80000, 32'h41100000);
      wait_done(cyc);
      check_result(cyc);
   endtask

   task automatic test_reset_mid();
      drive_start(32'h40A00000, 32'h40400000);
      repeat (8) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (result !== 32'd0) begin n_fail++; $display("FAIL midreset_result: got %h, required 0", result); end
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b, required 0", done); end
      n_checks++;
      if (exception !== 2'b00) begin n_fail++; $display("FAIL midreset_exc: got %b, required 00", exception); end
      @(negedge clk);
      rst_n = 1'b1;
      push_model(32'h40A00000, 32'h40400000); run_op(32'h40A00000, 32'h40400000);
   endtask

   initial begin
      test_reset();
      test_normal();
      test_sign();
      test_specials();
      test_random();
      test_done_hold();
      test_back_to_back();
      test_restart();
      test_reset_mid();
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
